fsm_job_arbiter: RTL and testbench

//  Shares one start/done FSM engine between N_REQ requesters. Picks a requester

---
 rtl/fsm_job_arbiter_if.sv | 38 +++
 rtl/fsm_job_arbiter.sv | 114 +++++++++++
 tb/tb_fsm_job_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fsm_job_arbiter_if.sv
// Requester and engine handshake bundle for the shared job arbiter.
// The arbiter side is slave; clients plus engine form the master side.
interface fsm_job_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] ack;
    logic [IDW-1:0]   grant_id;
    logic             eng_start;
    logic             eng_done;
    logic             busy;
    logic             timeout_err;

    modport master (
        output req,
        output eng_done,
        input  gnt,
        input  ack,
        input  grant_id,
        input  eng_start,
        input  busy,
        input  timeout_err
    );

    modport slave (
        input  req,
        input  eng_done,
        output gnt,
        output ack,
        output grant_id,
        output eng_start,
        output busy,
        output timeout_err
    );
endinterface

// File: rtl/fsm_job_arbiter.sv
// Round-robin arbiter sharing one start/done engine among N_REQ clients,
// with a watchdog that aborts a job the engine never finishes.
module fsm_job_arbiter #(
    parameter  int N_REQ   = 4,
    parameter  int TIMEOUT = 16,
    localparam int TMR_W   = $clog2(TIMEOUT + 1)
) (
    input logic               clk,
    input logic               rst,
    fsm_job_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        DONE
    } state_t;

    state_t           state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] ack_q;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   last_q;
    logic [TMR_W-1:0] tmr_q;
    logic             start_q;
    logic             busy_q;
    logic             terr_q;

    logic [IDW-1:0]   win_d;
    logic             found_d;

    // Scan downward so the candidate nearest to last+1 overwrites the rest.
    always_comb begin
        win_d   = '0;
        found_d = 1'b0;
        for (int i = N_REQ; i >= 1; i--) begin
            int             idx;
            logic [IDW-1:0] idx_w;
            idx = int'(last_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            idx_w = IDW'(idx);
            if (bus.req[idx_w]) begin
                win_d   = idx_w;
                found_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            id_q    <= '0;
            last_q  <= IDW'(N_REQ - 1);
            tmr_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (found_d) begin
                        id_q    <= win_d;
                        gnt_q   <= N_REQ'(1) << win_d;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    start_q <= 1'b0;
                    tmr_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    tmr_q <= tmr_q + 1'b1;
                    // A done arriving on the last watchdog cycle still counts.
                    if (bus.eng_done) begin
                        ack_q   <= gnt_q;
                        terr_q  <= 1'b0;
                        state_q <= DONE;
                    end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                        ack_q   <= gnt_q;
                        terr_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    ack_q   <= '0;
                    terr_q  <= 1'b0;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    last_q  <= id_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.ack         = ack_q;
    assign bus.grant_id    = id_q;
    assign bus.eng_start   = start_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_fsm_job_arbiter.sv
// Scoreboard bench for fsm_job_arbiter: jobs push expected acks,
// a forked monitor pops and compares whenever an ack appears.
module tb_fsm_job_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    fsm_job_arbiter_if #(.N_REQ(N)) bus ();

    fsm_job_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] g;
        logic       e;
        logic [1:0] id;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic chk4(input string name, input logic [3:0] act,
                        input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.ack != 4'b0) begin
                if (sbq.size() == 0) begin
                    chk4("ack_unexpected", bus.ack, 4'b0);
                end else begin
                    e = sbq.pop_front();
                    chk4("ack", bus.ack, e.g);
                    chk4("ack_gnt", bus.gnt, e.g);
                    chk4("ack_terr", 4'(bus.timeout_err), 4'(e.e));
                    chk4("ack_id", 4'(bus.grant_id), 4'(e.id));
                end
            end else if (bus.timeout_err) begin
                chk4("terr_no_ack", 4'(bus.timeout_err), 4'b0);
            end
        end
    endtask

    // k: cycles after start to pulse done (<0 never); drop_n: cycle to drop req.
    task automatic run_job(input logic [3:0] g, input logic [1:0] id,
                           input int k, input bit err, input int exp_w,
                           input int drop_n);
        int   w;
        int   n;
        int   starts;
        bit   held;
        exp_t e;
        w = 0;
        while (!bus.eng_start && w < 12) begin
            @(negedge clk);
            w++;
        end
        chk4("start_seen", 4'(bus.eng_start), 4'd1);
        if (!bus.eng_start) return;
        if (exp_w >= 0) chki("start_lat", w, exp_w);
        chk4("start_gnt", bus.gnt, g);
        chk4("start_id", 4'(bus.grant_id), 4'(id));
        chk4("start_busy", 4'(bus.busy), 4'd1);
        e.g  = g;
        e.e  = err;
        e.id = id;
        sbq.push_back(e);
        starts = 0;
        held   = 1'b1;
        for (n = 1; n <= TO + 6; n++) begin
            @(negedge clk);
            bus.eng_done = (n == k);
            if (n == drop_n) bus.req = 4'b0;
            starts += int'(bus.eng_start);
            held &= (bus.gnt == g);
            if (bus.ack != 4'b0) break;
        end
        bus.eng_done = 1'b0;
        chki("ack_lat", n, (k >= 0 && k <= TO) ? k + 1 : TO + 1);
        chki("no_restart", starts, 0);
        chk4("gnt_held", 4'(held), 4'd1);
    endtask

    initial begin
        int  w;
        bit  act;
        bus.req      = 4'b0;
        bus.eng_done = 1'b0;
        fork
            monitor();
        join_none

        bus.req = 4'b1111;
        repeat (3) @(negedge clk);
        chk4("rst_gnt", bus.gnt, 4'b0);
        chk4("rst_ack", bus.ack, 4'b0);
        chk4("rst_start", 4'(bus.eng_start), 4'b0);
        chk4("rst_busy", 4'(bus.busy), 4'b0);
        chk4("rst_terr", 4'(bus.timeout_err), 4'b0);
        chk4("rst_id", 4'(bus.grant_id), 4'b0);
        rst = 1'b1;

        run_job(4'b0001, 2'd0, 1, 1'b0, 1, -1);
        run_job(4'b0010, 2'd1, 1, 1'b0, 2, -1);
        run_job(4'b0100, 2'd2, 1, 1'b0, 2, -1);
        run_job(4'b1000, 2'd3, 1, 1'b0, 2, -1);
        run_job(4'b0001, 2'd0, 1, 1'b0, 2, -1);
        bus.req = 4'b0;
        @(negedge clk);
        chk4("rr_idle_busy", 4'(bus.busy), 4'b0);

        bus.req = 4'b0100;
        run_job(4'b0100, 2'd2, 3, 1'b0, 1, -1);
        bus.req = 4'b0;
        @(negedge clk);
        chk4("single_busy", 4'(bus.busy), 4'b0);
        chk4("single_ack", bus.ack, 4'b0);

        bus.req = 4'b0010;
        run_job(4'b0010, 2'd1, -1, 1'b1, 1, -1);
        bus.req = 4'b0;
        @(negedge clk);
        bus.req = 4'b0010;
        run_job(4'b0010, 2'd1, TO, 1'b0, 1, -1);
        bus.req = 4'b0;
        @(negedge clk);

        act = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.eng_done = (i < 4);
            @(negedge clk);
            act |= bus.busy | bus.eng_start | (bus.gnt != 4'b0);
        end
        bus.eng_done = 1'b0;
        chk4("spurious_idle", 4'(act), 4'b0);

        bus.req = 4'b0100;
        run_job(4'b0100, 2'd2, 4, 1'b0, 1, 2);
        @(negedge clk);

        bus.req = 4'b0001;
        w = 0;
        while (!bus.eng_start && w < 12) begin
            @(negedge clk);
            w++;
        end
        chk4("abort_start", 4'(bus.eng_start), 4'd1);
        chk4("abort_gnt", bus.gnt, 4'b0001);
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        bus.req = 4'b0;
        @(negedge clk);
        chk4("mid_rst_gnt", bus.gnt, 4'b0);
        chk4("mid_rst_busy", 4'(bus.busy), 4'b0);
        chk4("mid_rst_start", 4'(bus.eng_start), 4'b0);
        chk4("mid_rst_ack", bus.ack, 4'b0);
        chk4("mid_rst_id", 4'(bus.grant_id), 4'b0);
        repeat (2) @(negedge clk);
        rst     = 1'b1;
        bus.req = 4'b1001;
        run_job(4'b0001, 2'd0, 2, 1'b0, 1, -1);
        bus.req = 4'b0;
        @(negedge clk);
        bus.req = 4'b1000;
        run_job(4'b1000, 2'd3, 1, 1'b0, 1, -1);
        bus.req = 4'b0;

        repeat (4) @(negedge clk);
        chki("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
